// File: rtl/lcd_source_sel_if.sv
// Pixel-path bundle between the LCD pixel generators, lcd_source_sel and dmg_lcd_ctl.
// The master drives coordinates, source pixels and sync inputs; the slave is the selector.
interface lcd_source_sel_if;
    logic        rpi_vsync;
    logic        newframe;
    logic        force_startup;
    logic [8:0]  lcd_xpos;
    logic [7:0]  lcd_ypos;
    logic [1:0]  ss_data;
    logic [1:0]  vram_data;
    logic [15:0] vram_rd_ad;
    logic [1:0]  pix_out;
    logic        live;

    modport master (
        output rpi_vsync, newframe, force_startup, lcd_xpos, lcd_ypos, ss_data, vram_data,
        input  vram_rd_ad, pix_out, live
    );

    modport slave (
        input  rpi_vsync, newframe, force_startup, lcd_xpos, lcd_ypos, ss_data, vram_data,
        output vram_rd_ad, pix_out, live
    );
endinterface

// File: rtl/lcd_source_sel.sv
// Frame-synchronous startup-screen / VRAM pixel source selector driven by rpi_vsync lock.
// Optional macro LCD_SOURCE_SEL_BLANK_EN inserts one blank frame on every source change.
module lcd_source_sel #(
    parameter int VSYNC_TIMEOUT = 400000,
    parameter int LOCK_FRAMES   = 4,
    parameter int VRAM_LAT      = 1
) (
    input  logic          clk_8m,
    input  logic          rst_n,
    lcd_source_sel_if.slave bus
);

    localparam int             TW       = $clog2(VSYNC_TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_MAX   = TW'(VSYNC_TIMEOUT);
    localparam logic [3:0]     LOCK_MAX = 4'(LOCK_FRAMES);

    typedef enum logic [2:0] {
        STARTUP  = 3'd0,
        ARMING   = 3'd1,
        PENDING  = 3'd2,
        LIVE     = 3'd3,
        DROPPING = 3'd4,
        BLANK    = 3'd5
    } state_t;

    state_t          state_r;
    logic [2:0]      sync_r;
    logic [TW-1:0]   to_cnt_r;
    logic [3:0]      lock_r;
    logic [1:0]      ss_pipe_r [VRAM_LAT];
    logic [1:0]      pix_r;
    logic            live_r;
    logic            edge_s;
    logic            lost_s;
`ifdef LCD_SOURCE_SEL_BLANK_EN
    logic            blank_to_live_r;
`endif

    // sync_r[1] is the synchronized level, sync_r[2] its previous value
    assign edge_s = sync_r[1] & ~sync_r[2];
    // an edge arriving together with the timeout wins
    assign lost_s = (to_cnt_r == TO_MAX) & ~edge_s;

    assign bus.vram_rd_ad = {bus.lcd_ypos, bus.lcd_xpos[7:0]};
    assign bus.pix_out    = pix_r;
    assign bus.live       = live_r;

    // vsync synchronizer and saturating loss timer
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 3'b000;
            to_cnt_r <= '0;
        end else begin
            sync_r <= {sync_r[1:0], bus.rpi_vsync};
            if (edge_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
        end
    end

    // startup-screen delay line matching the VRAM read latency
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VRAM_LAT; i++) ss_pipe_r[i] <= 2'b00;
        end else begin
            ss_pipe_r[0] <= bus.ss_data;
            for (int i = 1; i < VRAM_LAT; i++) ss_pipe_r[i] <= ss_pipe_r[i-1];
        end
    end

    // source selection FSM with registered pixel and live outputs
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= STARTUP;
            lock_r  <= 4'd0;
            pix_r   <= 2'b00;
            live_r  <= 1'b0;
`ifdef LCD_SOURCE_SEL_BLANK_EN
            blank_to_live_r <= 1'b0;
`endif
        end else begin
            if (state_r == LIVE || state_r == DROPPING) begin
                pix_r  <= bus.vram_data;
                live_r <= 1'b1;
            end else if (state_r == BLANK) begin
                pix_r  <= 2'b00;
                live_r <= 1'b0;
            end else begin
                pix_r  <= ss_pipe_r[VRAM_LAT-1];
                live_r <= 1'b0;
            end

            case (state_r)
                STARTUP: begin
                    // the arming edge is itself the first locked frame
                    if (edge_s && !bus.force_startup) begin
                        state_r <= ARMING;
                        lock_r  <= 4'd1;
                    end else begin
                        state_r <= STARTUP;
                        lock_r  <= 4'd0;
                    end
                end
                ARMING: begin
                    if (lost_s || bus.force_startup) begin
                        state_r <= STARTUP;
                    end else if (lock_r == LOCK_MAX) begin
                        state_r <= PENDING;
                    end else begin
                        state_r <= ARMING;
                    end
                    if (edge_s) begin
                        lock_r <= lock_r + 4'd1;
                    end else begin
                        lock_r <= lock_r;
                    end
                end
                PENDING: begin
                    if (lost_s || bus.force_startup) begin
                        state_r <= STARTUP;
                    end else if (bus.newframe) begin
`ifdef LCD_SOURCE_SEL_BLANK_EN
                        state_r         <= BLANK;
                        blank_to_live_r <= 1'b1;
`else
                        state_r <= LIVE;
`endif
                    end else begin
                        state_r <= PENDING;
                    end
                end
                LIVE: begin
                    if (lost_s || bus.force_startup) begin
                        state_r <= DROPPING;
                    end else begin
                        state_r <= LIVE;
                    end
                end
                DROPPING: begin
                    if (bus.newframe) begin
`ifdef LCD_SOURCE_SEL_BLANK_EN
                        state_r         <= BLANK;
                        blank_to_live_r <= 1'b0;
`else
                        state_r <= STARTUP;
`endif
                    end else if (edge_s && !bus.force_startup) begin
                        state_r <= LIVE;
                    end else begin
                        state_r <= DROPPING;
                    end
                end
`ifdef LCD_SOURCE_SEL_BLANK_EN
                BLANK: begin
                    if (bus.newframe) begin
                        state_r <= blank_to_live_r ? LIVE : STARTUP;
                    end else begin
                        state_r <= BLANK;
                    end
                end
`endif
                default: begin
                    state_r <= STARTUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_source_sel.sv
// Directed self-checking bench for lcd_source_sel: reset, lock, loss, recovery and force.
module tb_lcd_source_sel;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    lcd_source_sel_if bus ();

    lcd_source_sel #(
        .VSYNC_TIMEOUT (100),
        .LOCK_FRAMES   (4),
        .VRAM_LAT      (1)
    ) dut (
        .clk_8m (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        bus.rpi_vsync = 1'b1;
        repeat (3) tick();
        bus.rpi_vsync = 1'b0;
        repeat (47) tick();
    endtask

    task automatic pulse_nf();
        bus.newframe = 1'b1;
        tick();
        bus.newframe = 1'b0;
    endtask

    // frame boundary that changes source; with blanking a 00 frame sits in between
    task automatic switch_frame();
        pulse_nf();
`ifdef LCD_SOURCE_SEL_BLANK_EN
        tick();
        check_val("blank_pix", 16'(bus.pix_out), 16'h0000);
        check_val("blank_live", 16'(bus.live), 16'h0000);
        repeat (20) tick();
        pulse_nf();
`endif
    endtask

    initial begin
        n_total           = 0;
        n_bad             = 0;
        rst_n             = 1'b0;
        bus.rpi_vsync     = 1'b0;
        bus.newframe      = 1'b0;
        bus.force_startup = 1'b0;
        bus.lcd_xpos      = 9'h1A5;
        bus.lcd_ypos      = 8'h3C;
        bus.ss_data       = 2'b11;
        bus.vram_data     = 2'b10;
        repeat (3) tick();
        check_val("rst_pix", 16'(bus.pix_out), 16'h0000);
        check_val("rst_live", 16'(bus.live), 16'h0000);
        check_val("rd_ad_alias", bus.vram_rd_ad, 16'h3CA5);
        bus.lcd_xpos = 9'h09F;
        bus.lcd_ypos = 8'h8F;
        #1;
        check_val("rd_ad", bus.vram_rd_ad, 16'h8F9F);

        rst_n = 1'b1;
        tick();
        check_val("rel_pix_1", 16'(bus.pix_out), 16'h0000);
        tick();
        check_val("rel_pix_2", 16'(bus.pix_out), 16'h0003);

        // three pulses are not enough to lock
        bus.ss_data = 2'b01;
        repeat (3) vs_pulse();
        pulse_nf();
        repeat (5) tick();
        check_val("p3_live", 16'(bus.live), 16'h0000);
        check_val("p3_pix", 16'(bus.pix_out), 16'h0001);

        // fourth pulse locks; switch waits for newframe
        vs_pulse();
        check_val("pend_live", 16'(bus.live), 16'h0000);
        switch_frame();
        check_val("lock_edge_live", 16'(bus.live), 16'h0000);
        tick();
        check_val("lock_live", 16'(bus.live), 16'h0001);
        check_val("lock_pix", 16'(bus.pix_out), 16'h0002);

        // recovery inside DROPPING keeps the stream live across newframe
        repeat (110) tick();
        check_val("drop_live", 16'(bus.live), 16'h0001);
        vs_pulse();
        pulse_nf();
        repeat (3) tick();
        check_val("recov_live", 16'(bus.live), 16'h0001);
        check_val("recov_pix", 16'(bus.pix_out), 16'h0002);

        // loss: live held until the next frame boundary
        repeat (110) tick();
        check_val("loss_hold_live", 16'(bus.live), 16'h0001);
        check_val("loss_hold_pix", 16'(bus.pix_out), 16'h0002);
        switch_frame();
        tick();
        check_val("loss_live", 16'(bus.live), 16'h0000);
        check_val("loss_pix", 16'(bus.pix_out), 16'h0001);

        // relock, then force the startup screen
        repeat (4) vs_pulse();
        switch_frame();
        tick();
        check_val("relock_live", 16'(bus.live), 16'h0001);
        bus.force_startup = 1'b1;
        vs_pulse();
        check_val("force_hold", 16'(bus.live), 16'h0001);
        switch_frame();
        tick();
        check_val("force_live", 16'(bus.live), 16'h0000);
        check_val("force_pix", 16'(bus.pix_out), 16'h0001);
        repeat (5) vs_pulse();
        pulse_nf();
        repeat (3) tick();
        check_val("force_held_live", 16'(bus.live), 16'h0000);
        check_val("force_held_pix", 16'(bus.pix_out), 16'h0001);
        bus.force_startup = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
